// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters,
// with a bounded per-holder tenure and bubble-free handoff.
module mux_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] i,
  output logic [3:0]         grant,
  output logic [1:0]         select,
  output logic               busy,
  output logic [WIDTH-1:0]   y_out
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [HW-1:0] hold_cnt;

  logic [1:0]       search_start;
  logic             found;
  logic [1:0]       winner;
  logic             release_now;
  logic [WIDTH-1:0] lane [4];

  // First requester at or after start, wrapping mod 4; {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] k;
    res = '0;
    for (int off = 3; off >= 0; off--) begin
      k = start + 2'(off);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    search_start = (state == IDLE) ? ptr : select + 2'd1;
    {found, winner} = pick(req, search_start);
    release_now = !req[select] || (hold_cnt == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= 4'b0001 << winner;
            select   <= winner;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= select + 2'd1;
            if (found) begin
              grant    <= 4'b0001 << winner;
              select   <= winner;
              hold_cnt <= '0;
            end else begin
              grant    <= '0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane[k] = i[k*WIDTH +: WIDTH];
  end

  assign busy  = |grant;
  assign y_out = busy ? lane[select] : '0;

endmodule
